sandbox_command_engine: RTL and testbench

- Command-execution stage that sits between the wide UART receive/transmit block and the host.
- Consumes each 48-bit frame the UART block reports via dataReceived, decodes it as a register-file command, and executes it.
- Loads a 48-bit response onto the UART block's output bus and requests transmission.
- Drives a stretched activity LED.

---
 rtl/sandbox_command_engine.sv | 193 +++++++++++++++++++
 tb/tb_sandbox_command_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sandbox_command_engine.sv
// sandbox_command_engine: executes 48-bit register-file command frames
// received from the UART block and hands back a 48-bit response frame.
// Ports: masterClock, reset (sync, active-low); dataReceived/inputData in,
// clearDR ack out; transmitting in, transmitData/outputData out;
// rxIndicator stretched activity LED; busy high outside IDLE.
module sandbox_command_engine #(
    parameter int REG_COUNT   = 16,
    parameter int LED_STRETCH = 1200000,
    parameter int TX_TIMEOUT  = 255
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        dataReceived,
    input  logic [47:0] inputData,
    input  logic        transmitting,
    output logic        clearDR,
    output logic        transmitData,
    output logic [47:0] outputData,
    output logic        rxIndicator,
    output logic        busy
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int LW = $clog2(LED_STRETCH + 1);
    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [8:0]    REG_LIMIT = 9'(REG_COUNT);
    localparam logic [LW-1:0] LED_LOAD  = LW'(LED_STRETCH);
    localparam logic [TW-1:0] TX_LAST   = TW'(TX_TIMEOUT - 1);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_ECHO  = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h04;
    localparam logic [7:0] OP_COUNT = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        EXEC,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [47:0]   frame;
    logic [31:0]   frameCount;
    logic [LW-1:0] ledCount;
    logic [TW-1:0] waitCount;
    logic [31:0]   regFile [REG_COUNT];

    logic [7:0]    opcode;
    logic [7:0]    addr;
    logic [31:0]   operand;
    logic [AW-1:0] regIdx;
    logic          addrOk;
    logic [31:0]   regValue;

    logic [7:0]    execStatus;
    logic [31:0]   execResult;
    logic          regWrite;
    logic [31:0]   regWriteValue;

    assign opcode   = frame[47:40];
    assign addr     = frame[39:32];
    assign operand  = frame[31:0];
    assign regIdx   = frame[32 +: AW];
    assign addrOk   = {1'b0, addr} < REG_LIMIT;
    assign regValue = addrOk ? regFile[regIdx] : '0;

    always_comb begin
        execStatus    = 8'hEE;
        execResult    = '0;
        regWrite      = 1'b0;
        regWriteValue = operand;
        unique case (1'b1)
            (opcode == OP_WRITE): begin
                if (addrOk) begin
                    execStatus = 8'h80 | opcode;
                    execResult = operand;
                    regWrite   = 1'b1;
                end else begin
                    execStatus = 8'hEA;
                end
            end
            (opcode == OP_READ): begin
                if (addrOk) begin
                    execStatus = 8'h80 | opcode;
                    execResult = regValue;
                end else begin
                    execStatus = 8'hEA;
                end
            end
            (opcode == OP_ECHO): begin
                execStatus = 8'h80 | opcode;
                execResult = operand;
            end
            (opcode == OP_ADD): begin
                if (addrOk) begin
                    regWriteValue = regValue + operand;
                    execStatus    = 8'h80 | opcode;
                    execResult    = regWriteValue;
                    regWrite      = 1'b1;
                end else begin
                    execStatus = 8'hEA;
                end
            end
            (opcode == OP_COUNT): begin
                execStatus = 8'h80 | opcode;
                execResult = frameCount;
            end
            default: begin
                execStatus = 8'hEE;
            end
        endcase
    end

    always_ff @(posedge masterClock) begin
        if (!reset) begin
            state        <= IDLE;
            frame        <= '0;
            frameCount   <= '0;
            ledCount     <= '0;
            waitCount    <= '0;
            clearDR      <= 1'b0;
            transmitData <= 1'b0;
            outputData   <= '0;
            rxIndicator  <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            transmitData <= 1'b0;
            // LED is high while the counter is still nonzero after this edge
            rxIndicator  <= ledCount > LW'(1);
            if (ledCount != '0) begin
                ledCount <= ledCount - LW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (dataReceived) begin
                        frame       <= inputData;
                        frameCount  <= frameCount + 32'd1;
                        ledCount    <= LED_LOAD;
                        rxIndicator <= 1'b1;
                        clearDR     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!dataReceived) begin
                        clearDR <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    outputData   <= {execStatus, addr, execResult};
                    transmitData <= 1'b1;
                    if (regWrite) begin
                        regFile[regIdx] <= regWriteValue;
                    end
                    state <= SEND;
                end
                SEND: begin
                    waitCount <= '0;
                    state     <= WAIT_START;
                end
                WAIT_START: begin
                    if (transmitting) begin
                        state <= WAIT_DONE;
                    end else if (waitCount == TX_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        waitCount <= waitCount + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!transmitting) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sandbox_command_engine.sv
// tb_sandbox_command_engine: directed bench for sandbox_command_engine.
// Expected responses queue up at stimulus time and are popped on transmitData.
module tb_sandbox_command_engine;
    localparam int LED  = 30;
    localparam int TXTO = 255;

    logic        masterClock = 1'b0;
    logic        reset = 1'b0;
    logic        dataReceived = 1'b0;
    logic [47:0] inputData = '0;
    logic        transmitting;
    logic        clearDR;
    logic        transmitData;
    logic [47:0] outputData;
    logic        rxIndicator;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [47:0] sb[$];
    int          txPulses = 0;
    int          cyc = 0;
    int          txCnt = 0;
    logic        txEnable = 1'b1;

    always #5 masterClock = ~masterClock;

    sandbox_command_engine #(
        .REG_COUNT  (16),
        .LED_STRETCH(LED),
        .TX_TIMEOUT (TXTO)
    ) dut (
        .masterClock (masterClock),
        .reset       (reset),
        .dataReceived(dataReceived),
        .inputData   (inputData),
        .transmitting(transmitting),
        .clearDR     (clearDR),
        .transmitData(transmitData),
        .outputData  (outputData),
        .rxIndicator (rxIndicator),
        .busy        (busy)
    );

    // UART transmitter model: transmitting rises two cycles after the request
    always @(posedge masterClock) begin
        cyc <= cyc + 1;
        if (transmitData) txPulses <= txPulses + 1;
        if (transmitData && txEnable) txCnt <= 6;
        else if (txCnt > 0) txCnt <= txCnt - 1;
    end
    assign transmitting = (txCnt >= 1) && (txCnt <= 4);

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic raiseFrame(input logic [47:0] f, input logic [47:0] resp);
        sb.push_back(resp);
        inputData    = f;
        dataReceived = 1'b1;
    endtask

    task automatic ackFrame(input int hold);
        int n = 0;
        while (clearDR !== 1'b1 && n < 2000) begin
            @(negedge masterClock);
            n++;
        end
        chk("ackSeen", 48'(clearDR), 48'd1);
        repeat (hold) begin
            @(negedge masterClock);
            chk("clearHeld", 48'(clearDR), 48'd1);
        end
        dataReceived = 1'b0;
        @(negedge masterClock);
        chk("clearDrop", 48'(clearDR), 48'd0);
    endtask

    task automatic expectResponse(input string tag);
        int n = 0;
        logic [47:0] exp;
        while (transmitData !== 1'b1 && n < 2000) begin
            @(negedge masterClock);
            n++;
        end
        chk("txSeen", 48'(transmitData), 48'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 48'hx;
        chk(tag, outputData, exp);
        @(negedge masterClock);
        chk("txSingle", 48'(transmitData), 48'd0);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge masterClock);
            n++;
        end
        chk("idle", 48'(busy), 48'd0);
    endtask

    task automatic sendFrame(input logic [47:0] f, input logic [47:0] resp,
                             input string tag);
        raiseFrame(f, resp);
        ackFrame(0);
        expectResponse(tag);
        waitIdle();
    endtask

    initial begin
        int pulses0;
        int acceptCyc;
        int n;

        reset = 1'b0;
        repeat (3) @(negedge masterClock);
        chk("rstFlags", 48'({clearDR, transmitData, rxIndicator, busy}), 48'd0);
        chk("rstData", outputData, 48'd0);
        reset = 1'b1;
        @(negedge masterClock);

        pulses0 = txPulses;
        raiseFrame(48'h01_05_DEADBEEF, 48'h81_05_DEADBEEF);
        ackFrame(2);
        expectResponse("write5");
        waitIdle();
        chk("ledOn", 48'(rxIndicator), 48'd1);

        raiseFrame(48'h02_05_00000000, 48'h82_05_DEADBEEF);
        @(negedge masterClock);
        chk("clrLatency", 48'(clearDR), 48'd1);
        dataReceived = 1'b0;
        @(negedge masterClock);
        chk("execNoTx", 48'(transmitData), 48'd0);
        @(negedge masterClock);
        chk("txLatency", 48'(transmitData), 48'd1);
        expectResponse("read5");
        waitIdle();
        chk("pulses2", 48'(txPulses - pulses0), 48'd2);

        sendFrame(48'h01_02_FFFFFFFF, 48'h81_02_FFFFFFFF, "write2");
        sendFrame(48'h04_02_00000003, 48'h84_02_00000002, "addWrap");
        sendFrame(48'h02_02_00000000, 48'h82_02_00000002, "read2");

        sendFrame(48'h02_10_00000000, 48'hEA_10_00000000, "readOob");
        sendFrame(48'h01_10_11111111, 48'hEA_10_00000000, "writeOob");
        sendFrame(48'h04_10_00000001, 48'hEA_10_00000000, "addOob");
        sendFrame(48'h7F_01_12345678, 48'hEE_01_00000000, "badOp");
        sendFrame(48'h02_00_00000000, 48'h82_00_00000000, "read0");
        sendFrame(48'h02_01_00000000, 48'h82_01_00000000, "read1");
        sendFrame(48'h03_FF_CAFEBABE, 48'h83_FF_CAFEBABE, "echoFF");
        sendFrame(48'h02_05_00000000, 48'h82_05_DEADBEEF, "read5b");

        raiseFrame(48'h01_03_11111111, 48'h81_03_11111111);
        ackFrame(0);
        expectResponse("write3");
        n = 0;
        while (transmitting !== 1'b1 && n < 100) begin
            @(negedge masterClock);
            n++;
        end
        @(negedge masterClock);
        chk("busyWaitDone", 48'({busy, transmitting}), 48'd3);
        pulses0 = txPulses;
        reset = 1'b0;
        @(negedge masterClock);
        chk("rstMidFlags", 48'({clearDR, transmitData, rxIndicator, busy}), 48'd0);
        chk("rstMidData", outputData, 48'd0);
        repeat (2) @(negedge masterClock);
        reset = 1'b1;
        repeat (10) @(negedge masterClock);
        chk("noTxAfterRst", 48'(txPulses - pulses0), 48'd0);

        sendFrame(48'h02_03_00000000, 48'h82_03_00000000, "read3Rst");
        sendFrame(48'h03_00_00000055, 48'h83_00_00000055, "echo55");
        sendFrame(48'h02_05_00000000, 48'h82_05_00000000, "read5Rst");

        raiseFrame(48'h05_00_00000000, 48'h85_00_00000004);
        @(negedge masterClock);
        acceptCyc = cyc;
        chk("countClr", 48'(clearDR), 48'd1);
        dataReceived = 1'b0;
        expectResponse("count");
        waitIdle();
        n = 0;
        while (rxIndicator !== 1'b0 && n < 1000) begin
            @(negedge masterClock);
            n++;
        end
        chk("ledFall", 48'(cyc - acceptCyc), 48'(LED));

        txEnable = 1'b0;
        pulses0 = txPulses;
        raiseFrame(48'h03_07_0000ABCD, 48'h83_07_0000ABCD);
        ackFrame(0);
        expectResponse("timeoutResp");
        n = 1;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge masterClock);
            n++;
        end
        chk("timeoutLen", 48'(n), 48'(TXTO + 1));
        repeat (5) @(negedge masterClock);
        chk("timeoutPulses", 48'(txPulses - pulses0), 48'd1);
        txEnable = 1'b1;

        pulses0 = txPulses;
        raiseFrame(48'h03_01_00000AAA, 48'h83_01_00000AAA);
        ackFrame(0);
        raiseFrame(48'h03_02_00000BBB, 48'h83_02_00000BBB);
        expectResponse("heldA");
        ackFrame(1);
        expectResponse("heldB");
        waitIdle();
        repeat (10) @(negedge masterClock);
        chk("heldPulses", 48'(txPulses - pulses0), 48'd2);
        chk("sbEmpty", 48'(sb.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
